seq_shift_add_multiplier: RTL and testbench

- Sequential shift-and-add multiplier. It is the inverse of the array divider in the approx-softmax datapath: it multiplies a 9-bit operand A (divisor or sum) by an 8-bit operand B (quotient) to rebuild or scale values.
- Processes one multiplier bit per clock, LSB first, behind a valid/ready handshake on both input and output.
- Used for quotient*divisor reconstruction checks and exp-value scaling ahead of the divider.

---
 rtl/approx_softmax_pkg.sv | 14 +
 rtl/mul_add_row.sv | 27 ++
 rtl/seq_shift_add_multiplier.sv | 115 +++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_softmax_pkg.sv
// Shared constants and types for the approx-softmax multiplier path.
//   MUL_WA / MUL_WB / MUL_WP : multiplicand, multiplier and product widths
//   mul_state_t              : sequential multiplier FSM states
package approx_softmax_pkg;
  localparam int MUL_WA = 9;
  localparam int MUL_WB = 8;
  localparam int MUL_WP = MUL_WA + MUL_WB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;
endpackage

// File: rtl/mul_add_row.sv
// One shift-and-add row: sum = acc + (en ? (mcand << sh) : 0).
// Purely combinational; the multiplier reuses a single instance every cycle.
// Ports:
//   acc   in  WP-bit running partial product
//   mcand in  WA-bit multiplicand
//   sh    in  shift amount (current multiplier bit position)
//   en    in  current multiplier bit
//   sum   out WP-bit updated partial product
module mul_add_row #(
  parameter int WA = 9,
  parameter int WB = 8,
  parameter int CW = $clog2(WB),
  parameter int WP = WA + WB
) (
  input  logic [WP-1:0] acc,
  input  logic [WA-1:0] mcand,
  input  logic [CW-1:0] sh,
  input  logic          en,
  output logic [WP-1:0] sum
);
  logic [WP-1:0] shifted;

  always_comb begin
    shifted = WP'(mcand) << sh;
    sum     = acc + (en ? shifted : '0);
  end
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, LSB first.
// Optional build macro: MUL_ADD_REM_EN -- when defined, c is captured with the
// operands and preloaded into the accumulator so p = a*b + c.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   in_valid, in_ready  operand handshake (a, b, c sampled on accept)
//   a, b, c             multiplicand, multiplier, addend (addend optional)
//   out_valid, out_ready product handshake
//   p                   product, stable while out_valid
//   busy                high while iterating
//
// state | meaning
// IDLE  | ready for operands
// RUN   | WB add/shift iterations, one multiplier bit per cycle
// DONE  | first cycle registers p/out_valid, then holds until out_ready
module seq_shift_add_multiplier
  import approx_softmax_pkg::*;
#(
  parameter int WA = MUL_WA,
  parameter int WB = MUL_WB,
  localparam int WP = WA + WB
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  input  logic [WB-1:0] c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WP-1:0] p,
  output logic          busy
);
  localparam int CW = $clog2(WB);
  localparam logic [CW-1:0] LAST = CW'(WB - 1);

  mul_state_t    state;
  logic [WA-1:0] mcand;
  logic [WB-1:0] mplier;
  logic [WP-1:0] acc;
  logic [WP-1:0] acc_next;
  logic [WP-1:0] acc_init;
  logic [CW-1:0] cnt;

`ifdef MUL_ADD_REM_EN
  assign acc_init = WP'(c);
`else
  logic unused_c;
  assign unused_c = ^c;
  assign acc_init = '0;
`endif

  mul_add_row #(.WA(WA), .WB(WB), .CW(CW), .WP(WP)) u_row (
    .acc   (acc),
    .mcand (mcand),
    .sh    (cnt),
    .en    (mplier[0]),
    .sum   (acc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      p         <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= a;
            mplier   <= b;
            acc      <= acc_init;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          // Output register stage: p is loaded once, then held until consumed.
          if (!out_valid) begin
            out_valid <= 1'b1;
            p         <= acc;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (scoreboard on handshakes).
module tb_seq_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  opa = '0;
  logic [7:0]  opb = '0;
  logic [7:0]  opc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [16:0] p;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;
  int n_out = 0;
  int n_in = 0;
  logic [16:0] sb[$];
  logic        hold_valid = 1'b0;
  logic [16:0] hold_p = '0;

  seq_shift_add_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (opa),
    .b         (opb),
    .c         (opc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(logic [8:0] x, logic [7:0] y, logic [7:0] z);
    logic [16:0] r;
    r = 17'(x) * 17'(y);
`ifdef MUL_ADD_REM_EN
    r = r + 17'(z);
`endif
    return r;
  endfunction

  // Inputs change 1 time unit after posedge; monitor samples on negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (hold_valid) begin
          n_total++;
          if (p !== hold_p) $display("FAIL p_stable: p=%0d required %0d", p, hold_p);
          else n_pass++;
        end
        hold_valid = 1'b1;
        hold_p = p;
      end else begin
        hold_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: p=%0d with no pending operation", p);
        end else begin
          logic [16:0] e;
          e = sb.pop_front();
          if (p !== e) $display("FAIL sb_product: p=%0d required %0d", p, e);
          else n_pass++;
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(opa, opb, opc));
        n_in++;
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  task automatic drive_op(input logic [8:0] x, input logic [7:0] y, input logic [7:0] z,
                          output bit ok);
    bit got;
    ok = 1'b0;
    opa = x; opb = y; opc = z;
    in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      got = in_ready && rst_n;
      @(posedge clk);
      #1;
      if (got) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Returns edges until out_valid seen (-1 on timeout) and busy-high samples.
  task automatic wait_valid(output int n, output int nbusy);
    n = -1;
    nbusy = busy ? 1 : 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        n = i;
        break;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 17'd0)
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b p=%0d required 1 0 0 0",
               in_ready, out_valid, busy, p);
    else n_pass++;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string name, input logic [8:0] x, input logic [7:0] y,
                         input logic [7:0] z, input logic [16:0] exp_p);
    bit ok;
    int n, nb;
    out_ready = 1'b1;
    drive_op(x, y, z, ok);
    n_total++;
    if (!ok) begin
      $display("FAIL %s_accept: not accepted within bound", name);
      return;
    end
    n_pass++;
    wait_valid(n, nb);
    n_total++;
    if (n !== 9) $display("FAIL %s_latency: %0d cycles required 9", name, n);
    else n_pass++;
    n_total++;
    if (nb !== 8) $display("FAIL %s_busy: busy %0d cycles required 8", name, nb);
    else n_pass++;
    n_total++;
    if (p !== exp_p) $display("FAIL %s_p: p=%0d required %0d", name, p, exp_p);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL %s_drop: out_valid=%b required 0", name, out_valid);
    else n_pass++;
  endtask

  task automatic test_max();
    run_one("max", 9'd511, 8'd255, 8'd0, 17'h1FD01);
  endtask

  task automatic test_zero();
    run_one("zero_a", 9'd0, 8'd200, 8'd0, 17'd0);
    run_one("zero_b", 9'd300, 8'd0, 8'd0, 17'd0);
  endtask

  task automatic test_stall();
    bit ok;
    int n, nb;
    out_ready = 1'b0;
    drive_op(9'd3, 8'd100, 8'd0, ok);
    n_total++;
    if (!ok) begin
      $display("FAIL stall_accept: not accepted within bound");
      out_ready = 1'b1;
      return;
    end
    n_pass++;
    opa = 9'd7; opb = 8'd7; opc = 8'd9;
    in_valid = 1'b1;
    wait_valid(n, nb);
    n_total++;
    if (n !== 9) $display("FAIL stall_latency: %0d cycles required 9", n);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (out_valid !== 1'b1 || p !== 17'd300 || in_ready !== 1'b0)
        $display("FAIL stall_hold: cycle %0d out_valid=%b p=%0d in_ready=%b required 1 300 0",
                 i, out_valid, p, in_ready);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_midreset();
    bit ok;
    out_ready = 1'b1;
    drive_op(9'd511, 8'd255, 8'd0, ok);
    n_total++;
    if (!ok) $display("FAIL midrst_accept: not accepted within bound");
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || p !== 17'd0)
      $display("FAIL midrst_state: out_valid=%b in_ready=%b busy=%b p=%0d required 0 1 0 0",
               out_valid, in_ready, busy, p);
    else n_pass++;
    run_one("after_rst", 9'd1, 8'd1, 8'd0, 17'd1);
  endtask

  task automatic test_back_to_back();
    int base_out, base_in;
    base_out = n_out;
    base_in = n_in;
    fork
      begin
        bit ok;
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          drive_op(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)), ok);
          if (!ok) break;
        end
      end
      begin
        for (int cyc = 0; cyc < 20000 && (n_out - base_out) < 100; cyc++) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ((n_in - base_in) !== 100 || (n_out - base_out) !== 100 || sb.size() !== 0)
      $display("FAIL b2b_count: accepted=%0d produced=%0d pending=%0d required 100 100 0",
               n_in - base_in, n_out - base_out, sb.size());
    else n_pass++;
  endtask

`ifdef MUL_ADD_REM_EN
  task automatic test_mul_add();
    run_one("muladd_small", 9'd20, 8'd10, 8'd5, 17'd205);
    run_one("muladd_max", 9'd511, 8'd255, 8'd255, 17'd130560);
  endtask
`else
  task automatic test_c_ignored();
    run_one("c_ignored", 9'd20, 8'd10, 8'd5, 17'd200);
  endtask
`endif

  initial begin
    test_reset();
    test_max();
    test_zero();
    test_stall();
    test_midreset();
`ifdef MUL_ADD_REM_EN
    test_mul_add();
`else
    test_c_ignored();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
